// File: rtl/sorter_pkg.sv
// Shared definitions for the weight-sorter feed path: sorter widths and
// the feed arbiter state encoding.
package sorter_pkg;

    localparam int unsigned WEIGHT_W   = 12;
    localparam int unsigned GRP_W      = 3;
    localparam int unsigned NUM_GROUPS = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_GAP    = 2'd2,
        S_REPORT = 2'd3
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: grants the first requester strictly
// after ptr, wrapping. ptr must be < N.
module rr_picker #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            any
);

    logic            hi_any;
    logic            lo_any;
    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;

    // Lowest index above ptr wins; otherwise wrap to the lowest index at/below ptr.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_id  = '0;
        lo_id  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                if (i > int'(ptr)) begin
                    if (!hi_any) begin
                        hi_any = 1'b1;
                        hi_id  = ID_W'(i);
                    end
                end else if (!lo_any) begin
                    lo_any = 1'b1;
                    lo_id  = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        any   = hi_any | lo_any;
        id    = hi_any ? hi_id : lo_id;
        grant = '0;
        if (any) begin
            grant[id] = 1'b1;
        end
    end

endmodule

// File: rtl/sorter_feed_arbiter.sv
// Round-robin feed of NUM_REQ weigh stations into one shared weight sorter.
// Optional per-feeder served counters: SORTER_FEED_ARBITER_STATS_EN.
module sorter_feed_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned WEIGHT_W    = sorter_pkg::WEIGHT_W,
    parameter int unsigned GRP_W       = sorter_pkg::GRP_W,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  req_weight,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [WEIGHT_W-1:0]          sort_in,
    input  logic [GRP_W-1:0]             sort_currgrp,
    output logic                         busy,
    output logic                         result_valid,
    output logic [ID_W-1:0]              result_id,
    output logic [GRP_W-1:0]             result_grp,
    output logic                         drop_pulse,
    output logic [NUM_REQ*8-1:0]         served_cnt
);

    import sorter_pkg::*;

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WEIGHT_W-1:0]  weight_q, weight_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]  sort_in_q, sort_in_d;
    logic                 result_valid_q, result_valid_d;
    logic [ID_W-1:0]      result_id_q, result_id_d;
    logic [GRP_W-1:0]     result_grp_q, result_grp_d;
    logic                 drop_q, drop_d;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_any;
    logic [WEIGHT_W-1:0]  pick_weight;

    rr_picker #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    always_comb begin
        pick_weight = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_weight = req_weight[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            weight_q       <= '0;
            id_q           <= '0;
            ptr_q          <= ID_W'(NUM_REQ - 1);
            sort_in_q      <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_grp_q   <= '0;
            drop_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            weight_q       <= weight_d;
            id_q           <= id_d;
            ptr_q          <= ptr_d;
            sort_in_q      <= sort_in_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            result_grp_q   <= result_grp_d;
            drop_q         <= drop_d;
        end
    end

    // sort_in is registered, so it is loaded on the transition into HOLD
    // and cleared on the transition out of it.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        weight_d       = weight_q;
        id_d           = id_q;
        ptr_d          = ptr_q;
        sort_in_d      = '0;
        result_valid_d = 1'b0;
        result_id_d    = result_id_q;
        result_grp_d   = result_grp_q;
        drop_d         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    id_d     = pick_id;
                    ptr_d    = pick_id;
                    weight_d = pick_weight;
                    if (pick_weight != '0) begin
                        state_d   = S_HOLD;
                        cnt_d     = CNT_W'(HOLD_CYCLES - 1);
                        sort_in_d = pick_weight;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    sort_in_d = weight_q;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d        = S_REPORT;
                    result_valid_d = 1'b1;
                    result_id_d    = id_q;
                    result_grp_d   = sort_currgrp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE) ? pick_grant : '0;
        busy      = (state_q != S_IDLE);
    end

    assign sort_in      = sort_in_q;
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign result_grp   = result_grp_q;
    assign drop_pulse   = drop_q;

`ifdef SORTER_FEED_ARBITER_STATS_EN
    logic [NUM_REQ*8-1:0] served_q, served_d;

    always_comb begin
        served_d = served_q;
        if (result_valid_d) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (id_q == ID_W'(i) && served_q[i*8 +: 8] != 8'hFF) begin
                    served_d[i*8 +: 8] = served_q[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            served_q <= '0;
        end else begin
            served_q <= served_d;
        end
    end

    assign served_cnt = served_q;
`else
    assign served_cnt = '0;
`endif

endmodule

// File: tb/tb_sorter_feed_arbiter.sv
// Bench for sorter_feed_arbiter: directed scenarios then randomized traffic,
// checked each cycle against a transaction-timeline reference model.
module tb_sorter_feed_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned W     = 12;
    localparam int unsigned GW    = 3;
    localparam int unsigned H     = 2;
    localparam int unsigned G     = 2;
    localparam int unsigned DEPTH = 8192;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*W-1:0]    req_weight = '0;
    logic [N-1:0]      req_ready;
    logic [W-1:0]      sort_in;
    logic [GW-1:0]     sort_currgrp = '0;
    logic              busy;
    logic              result_valid;
    logic [IDW-1:0]    result_id;
    logic [GW-1:0]     result_grp;
    logic              drop_pulse;
    logic [N*8-1:0]    served_cnt;

    always #5 clk = ~clk;

    sorter_feed_arbiter #(
        .NUM_REQ     (N),
        .ID_W        (IDW),
        .WEIGHT_W    (W),
        .GRP_W       (GW),
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_weight   (req_weight),
        .req_ready    (req_ready),
        .sort_in      (sort_in),
        .sort_currgrp (sort_currgrp),
        .busy         (busy),
        .result_valid (result_valid),
        .result_id    (result_id),
        .result_grp   (result_grp),
        .drop_pulse   (drop_pulse),
        .served_cnt   (served_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int free_at = 0;
    int ptr = N - 1;
    bit rand_mode = 1'b0;

    bit pend[N];
    int pw[N];
    int cnt[N];

    bit exp_rv[DEPTH];
    bit exp_drop[DEPTH];
    int exp_sort[DEPTH];
    int exp_id[DEPTH];
    int cg_hist[DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs, advance the model.
    task automatic step(input bit rst);
        int g;
        int t;
        logic [N-1:0] rdy_exp;
        @(posedge clk);
        #1;
        reset = rst;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 99) < 25) begin
                        pend[i] = 1'b1;
                        pw[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4095));
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    pend[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_weight[i*W +: W] = W'(pw[i]);
        end
        sort_currgrp = GW'($urandom_range(0, 5));
        cg_hist[cyc] = int'(sort_currgrp);

        @(negedge clk);
        g = -1;
        if (cyc >= free_at) begin
            for (int k = 1; k <= N; k++) begin
                t = (ptr + k) % N;
                if (g < 0 && pend[t]) g = t;
            end
        end
        rdy_exp = '0;
        if (g >= 0) rdy_exp[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(rdy_exp));
        check("sort_in", 32'(sort_in), 32'(exp_sort[cyc]));
        check("busy", 32'(busy), 32'(cyc < free_at));
        check("result_valid", 32'(result_valid), 32'(exp_rv[cyc]));
        check("drop_pulse", 32'(drop_pulse), 32'(exp_drop[cyc]));
        if (exp_rv[cyc]) begin
            check("result_id", 32'(result_id), 32'(exp_id[cyc]));
            check("result_grp", 32'(result_grp), 32'(cg_hist[cyc-1]));
            if (cnt[exp_id[cyc]] < 255) cnt[exp_id[cyc]]++;
        end
        for (int i = 0; i < N; i++) begin
`ifdef SORTER_FEED_ARBITER_STATS_EN
            check("served_cnt", 32'(served_cnt[i*8 +: 8]), 32'(cnt[i]));
`else
            check("served_cnt", 32'(served_cnt[i*8 +: 8]), 32'd0);
`endif
        end

        if (rst) begin
            for (int j = cyc + 1; j <= cyc + int'(H + G) + 2; j++) begin
                exp_rv[j] = 1'b0;
                exp_drop[j] = 1'b0;
                exp_sort[j] = 0;
            end
            ptr = N - 1;
            free_at = cyc + 1;
            for (int i = 0; i < N; i++) cnt[i] = 0;
        end else if (g >= 0) begin
            ptr = g;
            pend[g] = 1'b0;
            if (pw[g] != 0) begin
                for (int j = 1; j <= int'(H); j++) exp_sort[cyc + j] = pw[g];
                exp_rv[cyc + int'(H + G) + 1] = 1'b1;
                exp_id[cyc + int'(H + G) + 1] = g;
                free_at = cyc + int'(H + G) + 2;
            end else begin
                exp_drop[cyc + 1] = 1'b1;
                free_at = cyc + 1;
            end
        end
        cyc++;
    endtask

    initial begin
        bit rr;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pw[i] = 0;
            cnt[i] = 0;
        end
        @(posedge clk);
        step(1'b1);
        step(1'b0);
        repeat (3) step(1'b0);

        pend[0] = 1'b1; pw[0] = 250;
        repeat (8) step(1'b0);

        step(1'b1);
        pend[0] = 1'b1; pw[0] = 300;
        pend[1] = 1'b1; pw[1] = 501;
        pend[2] = 1'b1; pw[2] = 2001;
        repeat (20) step(1'b0);

        pend[3] = 1'b1; pw[3] = 0;
        repeat (4) step(1'b0);

        pend[1] = 1'b1; pw[1] = 512;
        step(1'b0);
        pend[0] = 1'b1; pw[0] = 77;
        step(1'b1);
        repeat (10) step(1'b0);

        rand_mode = 1'b1;
        repeat (3000) begin
            rr = (cyc < free_at) && ($urandom_range(0, 199) == 0);
            step(rr);
        end
        rand_mode = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (10) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
